siso_block_ctrl: RTL and testbench

- Sequencer in front of the SISO decoder datapath: captures one code block of LLR samples into external block RAM, then replays it as a forward pass and a backward pass.
- Per info bit, two LLR samples (systematic, parity) arrive on `in`/`valid_in`, and one a-priori LLR on `valid_apriori`.
- Drives the RAM write/read addresses and the forward/backward enables of the branch-metric and recursion units.
- Reports busy/done/error to the iteration controller.

---
 rtl/siso_pkg.sv | 25 ++
 rtl/siso_addr_cnt.sv | 49 ++++
 rtl/siso_block_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_siso_block_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared types and constants for the SISO block sequencer.
package siso_pkg;

  localparam int LLR_W      = 16;
  localparam int ADDR_W     = 13;
  localparam int MAX_BLKLEN = 6144;
  localparam int MIN_BLKLEN = 40;
  localparam int TAIL_BITS  = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FWD  = 3'd2,
    BWD  = 3'd3,
    DONE = 3'd4
  } siso_state_t;

  // A block length is legal when it lies in range and is a multiple of 8.
  function automatic logic blklen_legal(input logic [ADDR_W-1:0] k);
    return (k >= ADDR_W'(MIN_BLKLEN)) &&
           (k <= ADDR_W'(MAX_BLKLEN)) &&
           (k[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/siso_addr_cnt.sv
// Loadable up/down address counter with a terminal-count compare.
// Saturates at both ends instead of wrapping.
module siso_addr_cnt
  import siso_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up,
  input  logic         down,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load beats up beats down; no wrap-around.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (up && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end else if (down && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/siso_block_ctrl.sv
// SISO block sequencer: loads one code block of LLRs into RAM, then replays
// it as a forward pass followed by a backward pass.
// Optional trellis termination: define SISO_BLOCK_CTRL_TAIL_EN to expect
// TAIL_BITS extra sys/par pairs and extend both passes by the same amount.
//
// Handshake: ready_in is high for the whole LOAD state. A valid_in or
// valid_apriori strobe is taken only when ready_in is high and its stream
// has not yet reached its count limit; any other strobe is discarded and
// latches drop_err until the next accepted start.
module siso_block_ctrl
  import siso_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] blklen,
  input  logic              valid_in,
  input  logic              valid_apriori,
  output logic              ready_in,
  output logic              llr_wr_en,
  output logic [ADDR_W-1:0] llr_wr_addr,
  output logic              llr_wr_sel,
  output logic              ap_wr_en,
  output logic [ADDR_W-1:0] ap_wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              fwd_en,
  output logic              bwd_en,
  output logic              pass_last,
  output logic              busy,
  output logic              done,
  output logic              err_blklen,
  output logic              drop_err,
  output siso_state_t       dbg_state
);

`ifdef SISO_BLOCK_CTRL_TAIL_EN
  localparam logic [ADDR_W-1:0] TAIL_LEN = ADDR_W'(TAIL_BITS);
`else
  localparam logic [ADDR_W-1:0] TAIL_LEN = '0;
`endif

  siso_state_t       state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic              phase_q, phase_d;
  logic              drop_err_q, drop_err_d;
  logic              err_q, err_d;
  logic              llr_wr_en_q, llr_wr_en_d;
  logic [ADDR_W-1:0] llr_wr_addr_q, llr_wr_addr_d;
  logic              llr_wr_sel_q, llr_wr_sel_d;
  logic              ap_wr_en_q, ap_wr_en_d;
  logic [ADDR_W-1:0] ap_wr_addr_q, ap_wr_addr_d;

  logic [ADDR_W-1:0] kt;
  logic [ADDR_W-1:0] kt_m1;
  logic [ADDR_W-1:0] b_cnt, a_cnt, rd_cnt;
  logic              b_tc, a_tc, rd_tc;
  logic [ADDR_W-1:0] rd_term;
  logic              start_ok;
  logic              in_load, in_fwd, in_bwd;
  logic              accept_in, accept_ap;

  // Number of sys/par pairs in the block (K, plus the tail when enabled).
  assign kt    = k_q + TAIL_LEN;
  assign kt_m1 = kt - 1'b1;

  assign in_load  = (state_q == LOAD);
  assign in_fwd   = (state_q == FWD);
  assign in_bwd   = (state_q == BWD);
  assign start_ok = (state_q == IDLE) && start && blklen_legal(blklen);

  // Strobes are taken only in LOAD and only while their stream is short.
  assign accept_in = in_load && valid_in && !b_tc;
  assign accept_ap = in_load && valid_apriori && !a_tc;

  // Forward pass stops at the last pair, backward pass stops at zero.
  assign rd_term = in_fwd ? kt_m1 : '0;

  // Bit counter b: advances after each parity sample.
  siso_addr_cnt #(.W(ADDR_W)) u_b_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .load     (1'b0),
    .load_val ('0),
    .up       (accept_in && phase_q),
    .down     (1'b0),
    .term     (kt),
    .cnt      (b_cnt),
    .tc       (b_tc)
  );

  // A-priori counter a: advances with every accepted a-priori strobe.
  siso_addr_cnt #(.W(ADDR_W)) u_a_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .load     (1'b0),
    .load_val ('0),
    .up       (accept_ap),
    .down     (1'b0),
    .term     (k_q),
    .cnt      (a_cnt),
    .tc       (a_tc)
  );

  // Read counter: up through FWD, held at the turnaround, down through BWD.
  siso_addr_cnt #(.W(ADDR_W)) u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .load     (in_fwd && rd_tc),
    .load_val (kt_m1),
    .up       (in_fwd && !rd_tc),
    .down     (in_bwd && !rd_tc),
    .term     (rd_term),
    .cnt      (rd_cnt),
    .tc       (rd_tc)
  );

  // Next-state logic for the block sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = LOAD;
      LOAD:    if (b_tc && a_tc) state_d = FWD;
      FWD:     if (rd_tc) state_d = BWD;
      BWD:     if (rd_tc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Block length latch, sample phase, write strobes and error flags.
  always_comb begin
    k_d           = k_q;
    phase_d       = phase_q;
    drop_err_d    = drop_err_q;
    err_d         = (state_q == IDLE) && start && !blklen_legal(blklen);
    llr_wr_en_d   = accept_in;
    llr_wr_addr_d = llr_wr_addr_q;
    llr_wr_sel_d  = llr_wr_sel_q;
    ap_wr_en_d    = accept_ap;
    ap_wr_addr_d  = ap_wr_addr_q;

    if (start_ok) begin
      k_d        = blklen;
      phase_d    = 1'b0;
      drop_err_d = 1'b0;
    end else if (accept_in) begin
      phase_d = ~phase_q;
    end

    if (accept_in) begin
      llr_wr_addr_d = b_cnt;
      llr_wr_sel_d  = phase_q;
    end
    if (accept_ap) begin
      ap_wr_addr_d = a_cnt;
    end

    // A discarded strobe wins over a same-cycle clear.
    if ((valid_in && !accept_in) || (valid_apriori && !accept_ap)) begin
      drop_err_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      phase_q       <= 1'b0;
      drop_err_q    <= 1'b0;
      err_q         <= 1'b0;
      llr_wr_en_q   <= 1'b0;
      llr_wr_addr_q <= '0;
      llr_wr_sel_q  <= 1'b0;
      ap_wr_en_q    <= 1'b0;
      ap_wr_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      phase_q       <= phase_d;
      drop_err_q    <= drop_err_d;
      err_q         <= err_d;
      llr_wr_en_q   <= llr_wr_en_d;
      llr_wr_addr_q <= llr_wr_addr_d;
      llr_wr_sel_q  <= llr_wr_sel_d;
      ap_wr_en_q    <= ap_wr_en_d;
      ap_wr_addr_q  <= ap_wr_addr_d;
    end
  end

  assign ready_in    = in_load;
  assign llr_wr_en   = llr_wr_en_q;
  assign llr_wr_addr = llr_wr_addr_q;
  assign llr_wr_sel  = llr_wr_sel_q;
  assign ap_wr_en    = ap_wr_en_q;
  assign ap_wr_addr  = ap_wr_addr_q;
  assign rd_en       = in_fwd || in_bwd;
  assign rd_addr     = rd_cnt;
  assign fwd_en      = in_fwd;
  assign bwd_en      = in_bwd;
  assign pass_last   = (in_fwd || in_bwd) && rd_tc;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err_blklen  = err_q;
  assign drop_err    = drop_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_siso_block_ctrl.sv
// Bench for siso_block_ctrl: start-legality table, block runs against an
// event-list reference model, drop / reset / ignored-start corner cases.
`timescale 1ns/1ps
module tb_siso_block_ctrl;
  import siso_pkg::*;

`ifdef SISO_BLOCK_CTRL_TAIL_EN
  localparam int TAIL = 3;
`else
  localparam int TAIL = 0;
`endif
  localparam int MAX_WAIT = 40000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [ADDR_W-1:0] blklen = '0;
  logic              valid_in = 1'b0;
  logic              valid_apriori = 1'b0;
  logic              ready_in, llr_wr_en, llr_wr_sel, ap_wr_en;
  logic [ADDR_W-1:0] llr_wr_addr, ap_wr_addr, rd_addr;
  logic              rd_en, fwd_en, bwd_en, pass_last, busy, done;
  logic              err_blklen, drop_err;
  siso_state_t       dbg_state;
  logic [63:0]       all_outs;

  siso_block_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .blklen(blklen),
    .valid_in(valid_in), .valid_apriori(valid_apriori), .ready_in(ready_in),
    .llr_wr_en(llr_wr_en), .llr_wr_addr(llr_wr_addr), .llr_wr_sel(llr_wr_sel),
    .ap_wr_en(ap_wr_en), .ap_wr_addr(ap_wr_addr), .rd_en(rd_en),
    .rd_addr(rd_addr), .fwd_en(fwd_en), .bwd_en(bwd_en),
    .pass_last(pass_last), .busy(busy), .done(done),
    .err_blklen(err_blklen), .drop_err(drop_err), .dbg_state(dbg_state)
  );

  assign all_outs = 64'({ready_in, llr_wr_en, llr_wr_addr, llr_wr_sel,
                         ap_wr_en, ap_wr_addr, rd_en, rd_addr, fwd_en,
                         bwd_en, pass_last, busy, done, err_blklen, drop_err});

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          first_rd_cyc = -1;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic        both_seen = 1'b0;
  logic [15:0] got_wr_q[$];
  logic [15:0] got_ap_q[$];
  logic [15:0] got_rd_q[$];

  // Output monitor: logs every write/read event with its cycle number.
  always @(negedge clk) begin
    cyc++;
    if (llr_wr_en) begin
      got_wr_q.push_back({2'b00, llr_wr_sel, llr_wr_addr});
      last_wr_cyc = cyc;
    end
    if (ap_wr_en) begin
      got_ap_q.push_back({3'b000, ap_wr_addr});
      last_wr_cyc = cyc;
    end
    if (rd_en) begin
      got_rd_q.push_back({fwd_en, bwd_en, pass_last, rd_addr});
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_blklen) err_cnt++;
    if (fwd_en && bwd_en) both_seen = 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    got_wr_q.delete();
    got_ap_q.delete();
    got_rd_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    first_rd_cyc = -1;
    both_seen = 1'b0;
  endtask

  // Compare an observed event list with the expected one, stop at first miss.
  task automatic cmp_q(input string name, input logic [15:0] got[$], input logic [15:0] exp_q[$]);
    check({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), 64'(got[i]), 64'(exp_q[i]));
      if (got[i] !== exp_q[i]) break;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input int k);
    @(posedge clk); #1;
    blklen = ADDR_W'(k);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // mode 0: one LLR per cycle, a-priori every other cycle; mode 1: random gaps.
  task automatic stream(input int k, input int mode);
    int llr_left = 2 * (k + TAIL);
    int ap_left  = k;
    int i = 0;
    check("load_ready", 64'(ready_in), 64'd1);
    while (llr_left > 0 || ap_left > 0) begin
      valid_in      = (llr_left > 0) && ((mode == 0) || ($urandom_range(3, 0) != 0));
      valid_apriori = (ap_left > 0) && ((mode == 0) ? (i % 2 == 0) : ($urandom_range(1, 0) == 1));
      if (valid_in) llr_left--;
      if (valid_apriori) ap_left--;
      i++;
      @(posedge clk); #1;
    end
    valid_in      = 1'b0;
    valid_apriori = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("done_timeout", 64'd1, 64'd0);
    @(negedge clk); #1;
  endtask

  // ---------------- reference model / scoreboard ----------------
  // From the block rules: 2*Kt alternating sys/par writes at bit index i/2,
  // K a-priori writes, reads 0..Kt-1 forward then Kt-1..0 backward, one done.
  task automatic check_block(input int k);
    int kt = k + TAIL;
    logic [15:0] exp_wr[$];
    logic [15:0] exp_ap[$];
    logic [15:0] exp_rd[$];
    for (int i = 0; i < 2 * kt; i++)
      exp_wr.push_back({2'b00, 1'(i % 2), 13'(i / 2)});
    for (int i = 0; i < k; i++)
      exp_ap.push_back({3'b000, 13'(i)});
    for (int i = 0; i < kt; i++)
      exp_rd.push_back({1'b1, 1'b0, (i == kt - 1), 13'(i)});
    for (int i = kt - 1; i >= 0; i--)
      exp_rd.push_back({1'b0, 1'b1, (i == 0), 13'(i)});
    cmp_q("llr_wr", got_wr_q, exp_wr);
    cmp_q("ap_wr", got_ap_q, exp_ap);
    cmp_q("rd", got_rd_q, exp_rd);
    check("done_count", 64'(done_cnt), 64'd1);
    check("first_read_lat", 64'(first_rd_cyc - last_wr_cyc), 64'd1);
    check("done_lat", 64'(done_cyc - last_wr_cyc), 64'(2 * kt + 1));
    check("fwd_bwd_overlap", 64'(both_seen), 64'd0);
    check("block_err_pulse", 64'(err_cnt), 64'd0);
    check("block_drop_err", 64'(drop_err), 64'd0);
    check("block_idle", 64'(busy), 64'd0);
  endtask

  // ---------------- start-legality vectors ----------------
  typedef struct {
    int   k;
    logic rej;
  } start_vec_t;
  start_vec_t tbl[12];

  initial begin
    tbl[0]  = '{36,   1'b1};
    tbl[1]  = '{6152, 1'b1};
    tbl[2]  = '{44,   1'b1};
    tbl[3]  = '{0,    1'b1};
    tbl[4]  = '{32,   1'b1};
    tbl[5]  = '{8184, 1'b1};
    tbl[6]  = '{6148, 1'b1};
    tbl[7]  = '{40,   1'b0};
    tbl[8]  = '{48,   1'b0};
    tbl[9]  = '{6144, 1'b0};
    tbl[10] = '{1000, 1'b0};
    tbl[11] = '{6136, 1'b0};

    // Reset state.
    #100;
    check("reset_outputs", all_outs, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b1;

    // Start legality table.
    foreach (tbl[i]) begin
      clear_logs();
      do_start(tbl[i].k);
      @(negedge clk);
      check($sformatf("err_blklen_k%0d", tbl[i].k), 64'(err_blklen), 64'(tbl[i].rej));
      check($sformatf("busy_k%0d", tbl[i].k), 64'(busy), 64'(!tbl[i].rej));
      if (tbl[i].rej) begin
        @(negedge clk);
        check($sformatf("err_pulse_len_k%0d", tbl[i].k), 64'(err_blklen), 64'd0);
        check($sformatf("still_idle_k%0d", tbl[i].k), 64'(busy), 64'd0);
      end else begin
        #2 rst = 1'b0;
        #1 check($sformatf("abort_outputs_k%0d", tbl[i].k), all_outs, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
      end
    end

    // Strobes in IDLE set drop_err; a legal start clears it.
    @(posedge clk); #1;
    check("drop_err_initial", 64'(drop_err), 64'd0);
    valid_in = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    valid_in = 1'b0;
    check("drop_err_set", 64'(drop_err), 64'd1);

    // Main block: K=512, full-rate LLRs, half-rate a-priori.
    clear_logs();
    do_start(512);
    check("drop_err_cleared", 64'(drop_err), 64'd0);
    stream(512, 0);
    wait_done();
    check_block(512);

    // Random legal lengths with random strobe gaps.
    for (int r = 0; r < 3; r++) begin
      int k = 8 * int'($urandom_range(40, 5));
      clear_logs();
      do_start(k);
      stream(k, 1);
      wait_done();
      check_block(k);
    end

    // Start pulses in BWD and in DONE are ignored.
    begin
      int n = 0;
      clear_logs();
      do_start(40);
      stream(40, 1);
      while (!bwd_en && n < MAX_WAIT) begin @(negedge clk); n++; end
      if (!bwd_en) check("bwd_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      blklen = 13'd64;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("bwd_start_ignored", 64'(dbg_state), 64'(BWD));
      n = 0;
      while (!done && n < MAX_WAIT) begin @(negedge clk); n++; end
      if (!done) check("done_wait_timeout", 64'd1, 64'd0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_start_ignored_ready", 64'(ready_in), 64'd0);
      check("done_start_ignored_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      #1;
      check_block(40);
    end

    // Asynchronous reset in FWD at rd_addr=100 aborts without done.
    begin
      int n = 0;
      clear_logs();
      do_start(200);
      stream(200, 1);
      while (!(fwd_en && rd_addr == 13'd100) && n < MAX_WAIT) begin @(negedge clk); n++; end
      if (!(fwd_en && rd_addr == 13'd100)) check("fwd100_timeout", 64'd1, 64'd0);
      #2 rst = 1'b0;
      #1 check("midblock_reset_outputs", all_outs, 64'd0);
      repeat (5) @(negedge clk);
      #1;
      check("midblock_no_done", 64'(done_cnt), 64'd0);
      check("midblock_state", 64'(dbg_state), 64'(IDLE));
      #1 rst = 1'b1;
      clear_logs();
      do_start(40);
      stream(40, 0);
      wait_done();
      check_block(40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: the run must end on its own.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
